// File: rtl/mem_bus_if.sv
// mem_bus_if: bridge between the multicycle controller/datapath and the
// multiplexed address/data memory pads. The pad strobes and AdPadOut are all
// registered. Read data is captured on ENB and returned through RdData.
// The optional wait-state handshake (PadReady, Stall, timeout) is compiled in
// only when the macro MEM_WAIT_EN is defined.
//
// state | meaning
// IDLE  | no access in progress, pads idle
// ADDR  | address latched on pads, waiting for a read or write strobe
// READ  | read strobes on pads, capture on ENB
// WRITE | write data and write strobes on pads
// WAIT  | access frozen while memory is not ready
module mem_bus_if #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] SysBus,
  input  logic        ALE,
  input  logic        nME,
  input  logic        nOE,
  input  logic        nWE,
  input  logic        ENB,
  input  logic        MemEn,
  output logic [15:0] RdData,
  output logic        RdDataOe,
  output logic        Stall,
  output logic        BusErr,
  output logic [15:0] AdPadOut,
  input  logic [15:0] AdPadIn,
  output logic        AdPadOe,
  output logic        PadAle,
  output logic        PadnME,
  output logic        PadnOE,
  output logic        PadnWE,
  input  logic        PadReady
);

`ifdef MEM_WAIT_EN
  localparam logic WAIT_EN = 1'b1;
`else
  localparam logic WAIT_EN = 1'b0;
`endif
  localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_READ, S_WRITE, S_WAIT} state_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic        wait_rd, wait_rd_nxt;
  logic [15:0] ad_out_nxt, rd_nxt;
  logic        ad_oe_nxt, pad_ale_nxt, pad_nme_nxt, pad_noe_nxt, pad_nwe_nxt;
  logic        bus_err_nxt;

  logic acc_rd, acc_wr, acc_ill;
  logic op_stall_req, wait_busy, wait_timeout;

  assign acc_rd  = !nME && !nOE &&  nWE;
  assign acc_wr  = !nME && !nWE &&  nOE;
  assign acc_ill = !nME && !nOE && !nWE;

  // A stall starts from READ (with ENB) or WRITE while memory is not ready.
  assign op_stall_req = WAIT_EN && !PadReady && !ALE &&
                        ((state == S_READ && acc_rd && ENB) || (state == S_WRITE && acc_wr));
  // The entry cycle counts as the first stall cycle, so WAIT_MAX bounds the total.
  assign wait_busy    = (state == S_WAIT) && !ALE && !PadReady && (cnt < WAIT_LIM);
  assign wait_timeout = (state == S_WAIT) && !ALE && !PadReady && (cnt >= WAIT_LIM);

  assign Stall    = !Reset && (op_stall_req || wait_busy);
  assign RdDataOe = !Reset && MemEn;

  // State register with the stall counter and the stalled-operation flag.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= S_IDLE;
      cnt     <= 8'd0;
      wait_rd <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      wait_rd <= wait_rd_nxt;
    end
  end

  // Next-state logic; ALE overrides everything, including an active stall.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    wait_rd_nxt = wait_rd;
    if (ALE) begin
      state_nxt = S_ADDR;
      cnt_nxt   = 8'd0;
    end else if (state == S_WAIT) begin
      if (PadReady || cnt >= WAIT_LIM) begin
        state_nxt = wait_rd ? S_READ : S_WRITE;
        cnt_nxt   = 8'd0;
      end else begin
        cnt_nxt = cnt + 8'd1;
      end
    end else if (op_stall_req) begin
      state_nxt   = S_WAIT;
      cnt_nxt     = 8'd1;
      wait_rd_nxt = (state == S_READ);
    end else if (acc_ill) begin
      state_nxt = state;
    end else if (nME) begin
      state_nxt = S_IDLE;
    end else if (state != S_IDLE) begin
      if (acc_rd)      state_nxt = S_READ;
      else if (acc_wr) state_nxt = S_WRITE;
    end
  end

  // Next values of the registered pad outputs, read data and bus error.
  always_comb begin
    ad_out_nxt  = AdPadOut;
    ad_oe_nxt   = AdPadOe;
    rd_nxt      = RdData;
    pad_ale_nxt = 1'b0;
    pad_nme_nxt = PadnME;
    pad_noe_nxt = PadnOE;
    pad_nwe_nxt = PadnWE;
    bus_err_nxt = 1'b0;
    if (ALE) begin
      ad_out_nxt  = SysBus;
      ad_oe_nxt   = 1'b1;
      pad_ale_nxt = 1'b1;
      pad_nme_nxt = 1'b1;
      pad_noe_nxt = 1'b1;
      pad_nwe_nxt = 1'b1;
    end else if (state == S_WAIT) begin
      if (PadReady) begin
        if (wait_rd) rd_nxt = AdPadIn;
      end else if (wait_timeout) begin
        bus_err_nxt = 1'b1;
        if (wait_rd) rd_nxt = 16'hFFFF;
      end
    end else if (op_stall_req) begin
      ad_out_nxt = AdPadOut;
    end else if (acc_ill) begin
      ad_oe_nxt   = 1'b0;
      pad_nme_nxt = 1'b1;
      pad_noe_nxt = 1'b1;
      pad_nwe_nxt = 1'b1;
      bus_err_nxt = 1'b1;
    end else if (nME) begin
      ad_oe_nxt   = 1'b0;
      pad_nme_nxt = 1'b1;
      pad_noe_nxt = 1'b1;
      pad_nwe_nxt = 1'b1;
    end else if (state != S_IDLE) begin
      if (acc_rd) begin
        ad_oe_nxt   = 1'b0;
        pad_nme_nxt = 1'b0;
        pad_noe_nxt = 1'b0;
        pad_nwe_nxt = 1'b1;
        if (state == S_READ && ENB) rd_nxt = AdPadIn;
      end else if (acc_wr) begin
        ad_out_nxt  = SysBus;
        ad_oe_nxt   = 1'b1;
        pad_nme_nxt = 1'b0;
        pad_noe_nxt = 1'b1;
        pad_nwe_nxt = 1'b0;
      end
    end
  end

  // Output registers; nothing reaches the pads combinationally.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      AdPadOut <= 16'd0;
      AdPadOe  <= 1'b0;
      RdData   <= 16'd0;
      PadAle   <= 1'b0;
      PadnME   <= 1'b1;
      PadnOE   <= 1'b1;
      PadnWE   <= 1'b1;
      BusErr   <= 1'b0;
    end else begin
      AdPadOut <= ad_out_nxt;
      AdPadOe  <= ad_oe_nxt;
      RdData   <= rd_nxt;
      PadAle   <= pad_ale_nxt;
      PadnME   <= pad_nme_nxt;
      PadnOE   <= pad_noe_nxt;
      PadnWE   <= pad_nwe_nxt;
      BusErr   <= bus_err_nxt;
    end
  end

endmodule

// File: doc/mem_bus_if.md
# mem_bus_if

Bridge between the multicycle controller/datapath and the external multiplexed address/data memory pads. It latches the address on ALE and converts the controller's strobes into registered, glitch-free pad strobes. It captures read data on ENB and returns it to SysBus on MemEn. An optional wait-state handshake stalls the access when memory is slow and flags a bus error on timeout.

## Interface
- WAIT_MAX, 15: maximum consecutive stall cycles before timeout (1..255).
- Clock  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- SysBus  in  16  datapath bus carrying the address in the ALE cycle and the write data during a write.
- ALE, nME, nOE, nWE, ENB, MemEn  in  1 each  controller strobes; nME, nOE and nWE are active-low.
- RdData  out  16  captured read data, driven to SysBus by the datapath.
- RdDataOe  out  1  equals MemEn; forced 0 while Reset is high.
- Stall  out  1  access is waiting on memory; the controller must hold its state.
- BusErr  out  1  one-cycle pulse on timeout or illegal strobe combination.
- AdPadOut  out  16  address/data value driven to the pads.
- AdPadIn  in  16  pad input data.
- AdPadOe  out  1  pad output enable.
- PadAle, PadnME, PadnOE, PadnWE  out  1 each  registered pad strobes.
- PadReady  in  1  memory ready; used only when MEM_WAIT_EN is defined.

## Operation
- Reset values:
  - PadAle=0; PadnME=1, PadnOE=1, PadnWE=1.
  - AdPadOe=0, AdPadOut=0, RdData=0.
  - Stall=0, BusErr=0, state IDLE, stall counter 0.
- Access decode, from the inputs:
  - read = !nME & !nOE & nWE
  - write = !nME & !nWE & nOE
  - illegal = !nME & !nOE & !nWE
- States and transitions:
  - IDLE: goes to ADDR on ALE.
  - ADDR: goes to READ on read, to WRITE on write. Stays in ADDR while nME=0 with nOE=nWE=1. Goes to IDLE on nME=1 with ALE=0.
  - READ / WRITE: go to WAIT when a stall starts. Go to IDLE when nME=1.
  - WAIT: returns to READ or WRITE when the stall ends or times out.
  - ALE=1 in any state forces ADDR. Any stall in progress is abandoned, without a BusErr.
- ADDR entry:
  - AdPadOut <= SysBus, AdPadOe <= 1, PadAle <= 1.
  - PadAle is 0 in every other state.
- WRITE:
  - AdPadOut <= SysBus, AdPadOe <= 1.
  - PadnWE <= 0, PadnME <= 0.
- READ:
  - AdPadOe <= 0, PadnOE <= 0, PadnME <= 0.
  - RdData <= AdPadIn on any cycle with ENB=1 and no stall.
- illegal:
  - All pad strobes are driven high and AdPadOe=0.
  - BusErr pulses for 1 cycle.
  - State is unchanged.
- nME=1 and ALE=0:
  - All active-low pad strobes are driven high.
  - AdPadOe=0.
- RdData holds its value until the next capture.

## Timing
- Pad strobes and AdPadOut lag the controller inputs by exactly one cycle; there is no combinational path from inputs to pads.
- ALE in cycle N:
  - PadAle=1 and AdPadOut=address in cycle N+1.
  - The address is held until the next ALE or write.
- Fetch sequence ALE, nME=0, ENB, MemEn in cycles 0-3:
  - PadnME=0 and PadnOE=0 from cycle 2.
  - Capture at the cycle-2 clock edge.
  - RdData is valid in cycle 3 with RdDataOe=1.
- Stall, RdDataOe and BusErr:
  - Stall is combinational from the registered state and PadReady.
  - RdDataOe is combinational from MemEn.
  - BusErr is registered.
- Reset asserted mid-access: every output returns to its reset value on the next clock edge. Pad strobes deassert without completing the access.

## Configuration
- MEM_WAIT_EN defined:
  - In READ with ENB=1, or in WRITE, PadReady=0 raises Stall and moves to WAIT.
  - Pad strobes, AdPadOut and RdData freeze while stalled.
  - The stall counter increments each WAIT cycle.
  - PadReady=1 ends the stall: the capture or write completes that cycle and the counter clears.
  - Counter reaching WAIT_MAX ends the stall: BusErr pulses, RdData <= 16'hFFFF for a read, Stall drops and the counter clears.
- MEM_WAIT_EN undefined:
  - PadReady is ignored, Stall is tied 0 and WAIT is unreachable.
  - BusErr pulses only on illegal strobe combinations.

## Test plan
- Reset held 2 cycles with random inputs -> every output at its reset value; PadnME=PadnOE=PadnWE=1.
- Read, SysBus=16'h1234 with ALE, then memory returns AdPadIn=16'hBEEF on the ENB cycle -> AdPadOut=16'h1234 with PadAle=1 one cycle later; RdData=16'hBEEF; RdDataOe follows MemEn.
- Write to 16'h0040 with SysBus=16'hA5A5 in the write cycle -> AdPadOut=16'hA5A5, AdPadOe=1 and PadnWE=0 one cycle after the write strobe; PadnOE stays 1.
- Illegal strobes nME=nOE=nWE=0 -> BusErr high for exactly 1 cycle; all pad strobes high.
- MEM_WAIT_EN with PadReady=0 for 3 cycles during a read -> Stall high for 3 cycles with pads frozen; RdData captured on the cycle PadReady=1.
- MEM_WAIT_EN with PadReady=0 held for WAIT_MAX=15 cycles -> BusErr pulse; RdData=16'hFFFF; Stall=0 afterwards.
